ro_measure_ctrl: RTL and testbench

Measurement sequencer for the two-bit ring-oscillator PUF. It produces the `count0`/`count1` pair that the response comparator consumes. On a `start` pulse it enables both oscillators and waits a settling interval. It then counts synchronized rising edges of each oscillator over a fixed window of `clk` cycles and presents frozen counts with a one-cycle `done` strobe.

---
 rtl/ro_puf_pkg.sv | 18 +
 rtl/ro_edge_counter.sv | 52 +++++
 rtl/ro_measure_ctrl.sv | 111 +++++++++++
 tb/tb_ro_measure_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement path.
// Holds the sequencer state enum, default counter width and saturation max.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    localparam int CNT_W_DEF = 4;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizer, rising-edge detect and saturating edge counter for one RO.
// Ports: clk, reset_n, ro_in (async), clear, count_en -> count, sat.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ro_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(sat_max(CNT_W));

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ro_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (count_en && rise) begin
            if (count == CMAX) begin
                sat <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_measure_ctrl.sv
// Measurement sequencer: enable ROs, settle, count edges over a window.
// Ports: clk, reset_n, start, ro_in0/1 -> ro_en, busy, count0/1, sat, done.
module ro_measure_ctrl
    import ro_puf_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SETTLE      = 2,
    parameter int WINDOW      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             ro_in0,
    input  logic             ro_in1,
    output logic [1:0]       ro_en,
    output logic             busy,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [1:0]       sat,
    output logic             done
);

    localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t        state;
    logic [TW-1:0] timer;
    logic          clear;
    logic          count_en;

    assign clear    = (state == ST_IDLE) && start;
    assign count_en = (state == ST_COUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            timer <= '0;
            ro_en <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_SETTLE;
                        timer <= TW'(SETTLE - 1);
                        ro_en <= 2'b11;
                        busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer == '0) begin
                        state <= ST_COUNT;
                        timer <= TW'(WINDOW - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (timer == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ro_en <= 2'b00;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ro_en <= 2'b00;
                end
            endcase
        end
    end

    ro_edge_counter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cnt0 (
        .clk     (clk),
        .reset_n (reset_n),
        .ro_in   (ro_in0),
        .clear   (clear),
        .count_en(count_en),
        .count   (count0),
        .sat     (sat[0])
    );

    ro_edge_counter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cnt1 (
        .clk     (clk),
        .reset_n (reset_n),
        .ro_in   (ro_in1),
        .clear   (clear),
        .count_en(count_en),
        .count   (count1),
        .sat     (sat[1])
    );

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Directed bench for ro_measure_ctrl: default instance plus a WINDOW=48 one.
// Cycle k is the interval after acceptance edge E0 + k; sampled at negedge.
module tb_ro_measure_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       ro0 = 1'b0;
    logic       ro1 = 1'b0;
    logic [1:0] ro_en;
    logic       busy;
    logic [3:0] count0;
    logic [3:0] count1;
    logic [1:0] sat;
    logic       done;

    logic       wstart = 1'b0;
    logic       wro0 = 1'b0;
    logic       wro1 = 1'b0;
    logic [1:0] wro_en;
    logic       wbusy;
    logic [3:0] wcount0;
    logic [3:0] wcount1;
    logic [1:0] wsat;
    logic       wdone;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ro_measure_ctrl dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .ro_in0 (ro0),
        .ro_in1 (ro1),
        .ro_en  (ro_en),
        .busy   (busy),
        .count0 (count0),
        .count1 (count1),
        .sat    (sat),
        .done   (done)
    );

    ro_measure_ctrl #(
        .WINDOW(48)
    ) dut_w (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (wstart),
        .ro_in0 (wro0),
        .ro_in1 (wro1),
        .ro_en  (wro_en),
        .busy   (wbusy),
        .count0 (wcount0),
        .count1 (wcount1),
        .sat    (wsat),
        .done   (wdone)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string who);
        chk({who, " ro_en"}, 16'(ro_en), 16'd0);
        chk({who, " busy"}, 16'(busy), 16'd0);
        chk({who, " count0"}, 16'(count0), 16'd0);
        chk({who, " count1"}, 16'(count1), 16'd0);
        chk({who, " sat"}, 16'(sat), 16'd0);
        chk({who, " done"}, 16'(done), 16'd0);
    endtask

    // Caller raises start in cycle -1; this covers cycles 0..10.
    task automatic meas(input string tag, input logic [11:0] p0,
                        input logic [11:0] p1, input logic [11:0] smask,
                        input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] esat);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start = smask[k];
            ro0   = p0[k];
            ro1   = p1[k];
            chk({tag, " busy"}, 16'(busy), 16'(k < 10));
            chk({tag, " ro_en"}, 16'(ro_en), 16'(k < 10 ? 3 : 0));
            chk({tag, " done"}, 16'(done), 16'(k == 10));
            if (k == 0) begin
                chk({tag, " clr0"}, 16'(count0), 16'd0);
                chk({tag, " clr1"}, 16'(count1), 16'd0);
                chk({tag, " clrsat"}, 16'(sat), 16'd0);
            end
        end
        chk({tag, " count0"}, 16'(count0), e0);
        chk({tag, " count1"}, 16'(count1), e1);
        chk({tag, " sat"}, 16'(sat), esat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("rst");
        chk("rst w_done", 16'(wdone), 16'd0);
        chk("rst w_busy", 16'(wbusy), 16'd0);
        chk("rst w_ro_en", 16'(wro_en), 16'd0);

        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle done", 16'(done), 16'd0);
            chk("idle busy", 16'(busy), 16'd0);
        end

        // Basic: ro0 pulses 0,2,7 (last lands in final COUNT cycle).
        start = 1'b1;
        meas("basic", 12'h085, 12'h055, 12'h000, 16'd3, 16'd4, 16'd0);
        @(negedge clk);
        start = 1'b0;
        ro0 = 1'b0;
        ro1 = 1'b0;
        chk("basic c11 busy", 16'(busy), 16'd0);
        chk("basic c11 done", 16'(done), 16'd0);
        chk("basic hold0", 16'(count0), 16'd3);
        chk("basic hold1", 16'(count1), 16'd4);

        // Gating: edges detected in SETTLE (cycles 0,1) and after DONE.
        @(negedge clk);
        ro0 = 1'b1;
        @(negedge clk);
        ro0 = 1'b0;
        ro1 = 1'b1;
        start = 1'b1;
        meas("gate", 12'h500, 12'h500, 12'h000, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ro0 = 1'b0;
            ro1 = 1'b0;
            chk("gate hold0", 16'(count0), 16'd0);
            chk("gate hold1", 16'(count1), 16'd0);
        end

        // Start pulse in cycle 4 (mid-COUNT) must be ignored.
        start = 1'b1;
        meas("ign", 12'h001, 12'h004, 12'h010, 16'd1, 16'd1, 16'd0);
        @(negedge clk);
        start = 1'b0;
        chk("ign c11 busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("ign c12 busy", 16'(busy), 16'd0);

        // Retrigger: start held high, next acceptance in idle cycle 11.
        start = 1'b1;
        meas("rt1", 12'h001, 12'h000, 12'hFFF, 16'd1, 16'd0, 16'd0);
        @(negedge clk);
        start = 1'b1;
        chk("rt c11 busy", 16'(busy), 16'd0);
        chk("rt c11 done", 16'(done), 16'd0);
        chk("rt c11 cnt0", 16'(count0), 16'd1);
        meas("rt2", 12'h000, 12'h005, 12'hFFF, 16'd0, 16'd2, 16'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rt stop busy", 16'(busy), 16'd0);

        // Reset mid-COUNT.
        start = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            ro0 = (k == 0);
        end
        chk("mid count0", 16'(count0), 16'd1);
        chk("mid busy", 16'(busy), 16'd1);
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("midrst done", 16'(done), 16'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        meas("post", 12'h015, 12'h001, 12'h000, 16'd3, 16'd1, 16'd0);

        // Saturation on the wide instance: 20 ro0 edges, 5 ro1 edges.
        @(negedge clk);
        wstart = 1'b1;
        for (int k = 0; k <= 51; k++) begin
            @(negedge clk);
            wstart = 1'b0;
            wro0 = (k < 40) && (k % 2 == 0);
            wro1 = (k < 10) && (k % 2 == 0);
            if (k == 0 || k == 49 || k == 50 || k == 51) begin
                chk("wide done", 16'(wdone), 16'(k == 50));
                chk("wide busy", 16'(wbusy), 16'(k < 50));
            end
            if (k == 50) begin
                chk("wide count0", 16'(wcount0), 16'd15);
                chk("wide count1", 16'(wcount1), 16'd5);
                chk("wide sat", 16'(wsat), 16'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
